chacha_ks_prefetch: RTL and testbench

- Parametrised ChaCha keystream generator with a prefetch FIFO. Successor to the fixed ChaCha20 keystream path inside the chacha20_poly1305_core.
- Round count and quarter-round parallelism are build-time choices; counter auto-increments per block.
- Generated blocks queue in a DEPTH-entry buffer behind a valid/ready stream so the encrypt/MAC datapath never stalls on block latency.
- Sits between the config registers (key/nonce/ctr) and the XOR/Poly1305 datapath.

---
 rtl/chacha_ks_prefetch_if.sv | 24 ++
 rtl/chacha_ks_prefetch.sv | 192 +++++++++++++++++++
 tb/tb_chacha_ks_prefetch.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/chacha_ks_prefetch_if.sv
// Stream and configuration bundle for the ChaCha keystream prefetcher.
// master drives config and ks_ready; slave is the generator.
interface chacha_ks_prefetch_if;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  ctr_init;
    logic         cfg_we;
    logic         ks_valid;
    logic         ks_ready;
    logic [511:0] ks_data;
    logic [31:0]  ks_ctr;
    logic         busy;
    logic         ctr_wrap_err;

    modport master (
        output key, nonce, ctr_init, cfg_we, ks_ready,
        input  ks_valid, ks_data, ks_ctr, busy, ctr_wrap_err
    );

    modport slave (
        input  key, nonce, ctr_init, cfg_we, ks_ready,
        output ks_valid, ks_data, ks_ctr, busy, ctr_wrap_err
    );
endinterface

// File: rtl/chacha_ks_prefetch.sv
// ChaCha keystream engine (ROUNDS rounds, QR_PER_CYC quarter-rounds per cycle)
// feeding a DEPTH-entry first-word-fall-through prefetch FIFO.
//
// state   | meaning
// S_IDLE  | waiting for config, FIFO space, and no counter-wrap halt
// S_LOAD  | build input state from latched key/nonce and next_ctr
// S_ROUND | apply QR_PER_CYC quarter-rounds per cycle
// S_FINAL | add input state, push block, advance or halt the counter
module chacha_ks_prefetch #(
    parameter int ROUNDS     = 20,
    parameter int QR_PER_CYC = 4,
    parameter int DEPTH      = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    chacha_ks_prefetch_if.slave bus
);
    localparam int N_CYC = ROUNDS * 4 / QR_PER_CYC;
    localparam int RW    = $clog2(N_CYC);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_FINAL} state_t;
    typedef logic [15:0][31:0] blk_t;

    state_t        state;
    logic [255:0]  key_q;
    logic [95:0]   nonce_q;
    logic [31:0]   next_ctr;
    logic          configured;
    logic          busy_q;
    logic          wrap_err_q;
    logic [RW-1:0] rnd_cnt;
    logic [2:0]    qr_pos;
    blk_t          x, x_rnd, init_st, final_blk;

    blk_t          mem_data [DEPTH];
    logic [31:0]   mem_ctr  [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          valid_q;
    logic          push, pop;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic blk_t quarter(input blk_t s, input int a, input int b,
                                     input int c, input int d);
        blk_t t;
        t = s;
        t[a] = t[a] + t[b]; t[d] = rotl(t[d] ^ t[a], 16);
        t[c] = t[c] + t[d]; t[b] = rotl(t[b] ^ t[c], 12);
        t[a] = t[a] + t[b]; t[d] = rotl(t[d] ^ t[a], 8);
        t[c] = t[c] + t[d]; t[b] = rotl(t[b] ^ t[c], 7);
        return t;
    endfunction

    // pos 0-3: column QRs, pos 4-7: diagonal QRs of one double round
    function automatic blk_t qr_step(input blk_t s, input int pos);
        int i;
        i = pos % 4;
        if (pos < 4)
            return quarter(s, i, 4 + i, 8 + i, 12 + i);
        else
            return quarter(s, i, 4 + ((i + 1) % 4), 8 + ((i + 2) % 4), 12 + ((i + 3) % 4));
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        init_st[0]  = 32'h61707865;
        init_st[1]  = 32'h3320646e;
        init_st[2]  = 32'h79622d32;
        init_st[3]  = 32'h6b206574;
        for (int i = 0; i < 8; i++) init_st[4 + i] = key_q[32*i +: 32];
        init_st[12] = next_ctr;
        for (int i = 0; i < 3; i++) init_st[13 + i] = nonce_q[32*i +: 32];
    end

    always_comb begin
        x_rnd = x;
        for (int j = 0; j < QR_PER_CYC; j++) x_rnd = qr_step(x_rnd, (int'(qr_pos) + j) % 8);
    end

    always_comb begin
        for (int i = 0; i < 16; i++) final_blk[i] = x[i] + init_st[i];
    end

    assign push       = (state == S_FINAL) && !bus.cfg_we;
    assign pop        = valid_q && bus.ks_ready && !bus.cfg_we;
    assign count_next = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            key_q      <= '0;
            nonce_q    <= '0;
            next_ctr   <= '0;
            configured <= 1'b0;
            busy_q     <= 1'b0;
            wrap_err_q <= 1'b0;
            rnd_cnt    <= '0;
            qr_pos     <= '0;
            x          <= '0;
        end else if (bus.cfg_we) begin
            // restart wins over everything, including a block in FINAL
            key_q      <= bus.key;
            nonce_q    <= bus.nonce;
            next_ctr   <= bus.ctr_init;
            configured <= 1'b1;
            wrap_err_q <= 1'b0;
            state      <= S_LOAD;
            busy_q     <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (configured && !wrap_err_q && (count < CW'(DEPTH))) begin
                        state  <= S_LOAD;
                        busy_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    x       <= init_st;
                    rnd_cnt <= RW'(N_CYC - 1);
                    qr_pos  <= '0;
                    state   <= S_ROUND;
                end
                S_ROUND: begin
                    x       <= x_rnd;
                    qr_pos  <= qr_pos + 3'(QR_PER_CYC);
                    rnd_cnt <= rnd_cnt - 1'b1;
                    if (rnd_cnt == '0) state <= S_FINAL;
                end
                S_FINAL: begin
                    if (next_ctr == 32'hFFFF_FFFF) begin
                        wrap_err_q <= 1'b1;
                        state      <= S_IDLE;
                        busy_q     <= 1'b0;
                    end else begin
                        next_ctr <= next_ctr + 1'b1;
                        if (count_next < CW'(DEPTH)) begin
                            state <= S_LOAD;
                        end else begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_ctr[i]  <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
        end else if (bus.cfg_we) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= final_blk;
                mem_ctr[wr_ptr]  <= next_ctr;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            count   <= count_next;
            valid_q <= (count_next != '0);
        end
    end

    assign bus.ks_valid     = valid_q;
    assign bus.ks_data      = mem_data[rd_ptr];
    assign bus.ks_ctr       = mem_ctr[rd_ptr];
    assign bus.busy         = busy_q;
    assign bus.ctr_wrap_err = wrap_err_q;
endmodule

// File: tb/tb_chacha_ks_prefetch.sv
// Randomized and directed bench for chacha_ks_prefetch against a block-level
// ChaCha reference and a transaction scoreboard of expected counters.
module tb_chacha_ks_prefetch;
    typedef logic [15:0][31:0] blk_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    chacha_ks_prefetch_if bus();
    chacha_ks_prefetch_if b8();

    chacha_ks_prefetch #(.ROUNDS(20), .QR_PER_CYC(4), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));
    chacha_ks_prefetch #(.ROUNDS(8), .QR_PER_CYC(1), .DEPTH(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(b8.slave));

    localparam logic [255:0] RFC_KEY =
        256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [95:0]  RFC_NONCE = 96'h000000004a00000009000000;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic blk_t qr(input blk_t s, input int a, input int b, input int c, input int d);
        blk_t t;
        t = s;
        t[a] = t[a] + t[b]; t[d] = rotl(t[d] ^ t[a], 16);
        t[c] = t[c] + t[d]; t[b] = rotl(t[b] ^ t[c], 12);
        t[a] = t[a] + t[b]; t[d] = rotl(t[d] ^ t[a], 8);
        t[c] = t[c] + t[d]; t[b] = rotl(t[b] ^ t[c], 7);
        return t;
    endfunction

    function automatic logic [511:0] chacha_ref(input logic [255:0] k, input logic [95:0] n,
                                                input logic [31:0] c, input int rounds);
        blk_t s, w;
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4 + i] = k[32*i +: 32];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13 + i] = n[32*i +: 32];
        w = s;
        for (int r = 0; r < rounds / 2; r++) begin
            w = qr(w, 0, 4, 8, 12); w = qr(w, 1, 5, 9, 13);
            w = qr(w, 2, 6, 10, 14); w = qr(w, 3, 7, 11, 15);
            w = qr(w, 0, 5, 10, 15); w = qr(w, 1, 6, 11, 12);
            w = qr(w, 2, 7, 8, 13); w = qr(w, 3, 4, 9, 14);
        end
        for (int i = 0; i < 16; i++) w[i] = w[i] + s[i];
        return w;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: what the head of the stream must be, from config and transfers seen
    logic [255:0] mdl_key;
    logic [95:0]  mdl_nonce;
    logic [31:0]  mdl_ctr;
    logic         mdl_cfgd, mdl_done;
    logic         prev_hold, prev_cfg;
    logic [511:0] prev_data;
    logic [31:0]  prev_ctr;

    initial begin
        mdl_cfgd = 0; mdl_done = 0; prev_hold = 0; prev_cfg = 0;
        mdl_key = '0; mdl_nonce = '0; mdl_ctr = '0; prev_data = '0; prev_ctr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mdl_cfgd = 0; mdl_done = 0; prev_hold = 0; prev_cfg = 0;
            end else begin
                if (prev_cfg) begin
                    check("flush_valid", 512'(bus.ks_valid), 512'(0));
                    check("cfg_clears_err", 512'(bus.ctr_wrap_err), 512'(0));
                end
                if (prev_hold) begin
                    check("hold_valid", 512'(bus.ks_valid), 512'(1));
                    check("hold_data", bus.ks_data, prev_data);
                    check("hold_ctr", 512'(bus.ks_ctr), 512'(prev_ctr));
                end
                if (bus.ks_valid && !prev_cfg) begin
                    if (!mdl_cfgd || mdl_done) begin
                        check("unexpected_valid", 512'(bus.ks_valid), 512'(0));
                    end else begin
                        check("ks_ctr_seq", 512'(bus.ks_ctr), 512'(mdl_ctr));
                        check("ks_data", bus.ks_data, chacha_ref(mdl_key, mdl_nonce, bus.ks_ctr, 20));
                    end
                end
                if (bus.cfg_we) begin
                    mdl_key = bus.key; mdl_nonce = bus.nonce; mdl_ctr = bus.ctr_init;
                    mdl_cfgd = 1; mdl_done = 0;
                end else if (bus.ks_valid && bus.ks_ready) begin
                    if (bus.ks_ctr == 32'hFFFF_FFFF) begin
                        check("wrap_err_set", 512'(bus.ctr_wrap_err), 512'(1));
                        mdl_done = 1;
                    end
                    mdl_ctr = mdl_ctr + 1;
                end
                prev_cfg  = bus.cfg_we;
                prev_hold = bus.ks_valid && !bus.ks_ready && !bus.cfg_we;
                prev_data = bus.ks_data;
                prev_ctr  = bus.ks_ctr;
            end
        end
    end

    logic [31:0] got[$];

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_cfg(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
        bus.key = k; bus.nonce = n; bus.ctr_init = c; bus.cfg_we = 1'b1;
        step();
        bus.cfg_we = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int cyc);
        cyc = 0;
        while (!bus.ks_valid && cyc < limit) begin
            step();
            cyc++;
        end
    endtask

    task automatic collect(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if (bus.ks_valid && bus.ks_ready && !bus.cfg_we) got.push_back(bus.ks_ctr);
            step();
        end
    endtask

    initial begin
        int lat;
        blk_t qs;
        logic [511:0] ref_blk, held;
        logic [255:0] key_a, key_b;
        logic [95:0]  nonce_b;

        bus.key = '0; bus.nonce = '0; bus.ctr_init = '0; bus.cfg_we = 1'b0; bus.ks_ready = 1'b0;
        b8.key = '0; b8.nonce = '0; b8.ctr_init = '0; b8.cfg_we = 1'b0; b8.ks_ready = 1'b0;

        // pin the reference model with published vectors
        qs = '0;
        qs[0] = 32'h11111111; qs[1] = 32'h01020304; qs[2] = 32'h9b8d6f43; qs[3] = 32'h01234567;
        qs = qr(qs, 0, 1, 2, 3);
        check("model_qr", 512'({qs[3], qs[2], qs[1], qs[0]}),
              512'({32'h5881c4bb, 32'h4581472e, 32'hcb1cf8ce, 32'hea2a92f4}));
        ref_blk = chacha_ref(RFC_KEY, RFC_NONCE, 32'd1, 20);
        check("model_rfc_w0_3", 512'(ref_blk[127:0]),
              512'({32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110}));

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bus.ks_data[450:0], bus.ks_ctr, bus.ks_valid, bus.busy, bus.ctr_wrap_err}, '0);
        rst_n = 1'b1;
        repeat (30) step();
        check("no_gen_before_cfg", 512'({bus.ks_valid, bus.busy}), 512'(0));

        // RFC vector, first-block latency
        bus.ks_ready = 1'b1;
        do_cfg(RFC_KEY, RFC_NONCE, 32'd1);
        check("busy_after_cfg", 512'(bus.busy), 512'(1));
        wait_valid(100, lat);
        check("latency_rfc", 512'(lat), 512'(22));
        check("rfc_word0", 512'(bus.ks_data[31:0]), 512'(32'he4e7f110));
        check("rfc_word1", 512'(bus.ks_data[63:32]), 512'(32'h15593bd1));
        check("rfc_ctr", 512'(bus.ks_ctr), 512'(1));

        // back-pressure fills exactly DEPTH entries
        bus.ks_ready = 1'b0;
        do_cfg(RFC_KEY, RFC_NONCE, 32'd1);
        repeat (70) step();
        check("bp_busy_idle", 512'(bus.busy), 512'(0));
        check("bp_head_ctr", 512'(bus.ks_ctr), 512'(1));
        held = bus.ks_data;
        repeat (10) step();
        check("bp_data_stable", bus.ks_data, held);
        bus.ks_ready = 1'b1;
        got.delete();
        collect(75);
        check("bp_count", 512'(got.size() >= 4), 512'(1));
        for (int i = 0; i < 4 && i < got.size(); i++) check("bp_order", 512'(got[i]), 512'(i + 1));

        // counter wrap halts after 0xFFFFFFFF
        key_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        nonce_b = {$urandom, $urandom, $urandom};
        do_cfg(key_b, nonce_b, 32'hFFFF_FFFE);
        got.delete();
        collect(100);
        check("wrap_count", 512'(got.size()), 512'(2));
        if (got.size() == 2) begin
            check("wrap_ctr0", 512'(got[0]), 512'(32'hFFFF_FFFE));
            check("wrap_ctr1", 512'(got[1]), 512'(32'hFFFF_FFFF));
        end
        check("wrap_err", 512'(bus.ctr_wrap_err), 512'(1));
        check("wrap_not_busy", 512'(bus.busy), 512'(0));
        do_cfg(key_b, nonce_b, 32'd5);
        check("wrap_err_cleared", 512'(bus.ctr_wrap_err), 512'(0));

        // restart in the middle of a block
        bus.ks_ready = 1'b0;
        key_a = ~key_b;
        do_cfg(key_a, nonce_b, 32'd1);
        wait_valid(100, lat);
        repeat (12) step();
        check("restart_busy", 512'(bus.busy), 512'(1));
        do_cfg(key_b, nonce_b, 32'd100);
        check("restart_flush", 512'(bus.ks_valid), 512'(0));
        wait_valid(100, lat);
        check("restart_latency", 512'(lat), 512'(22));
        check("restart_ctr", 512'(bus.ks_ctr), 512'(100));
        check("restart_data", bus.ks_data, chacha_ref(key_b, nonce_b, 32'd100, 20));

        // reset with one block queued and the engine mid-round
        do_cfg(RFC_KEY, RFC_NONCE, 32'd7);
        repeat (32) step();
        rst_n = 1'b0;
        #1;
        check("rst_outputs", {bus.ks_data[450:0], bus.ks_ctr, bus.ks_valid, bus.busy, bus.ctr_wrap_err}, '0);
        step();
        rst_n = 1'b1;
        repeat (40) step();
        check("rst_no_output", 512'({bus.ks_valid, bus.busy}), 512'(0));

        // randomized traffic, scoreboard does the checking
        do_cfg(RFC_KEY, RFC_NONCE, $urandom);
        for (int c = 0; c < 4000; c++) begin
            bus.ks_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                key_a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                bus.key = key_a;
                bus.nonce = {$urandom, $urandom, $urandom};
                bus.ctr_init = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : $urandom;
                bus.cfg_we = 1'b1;
            end else begin
                bus.cfg_we = 1'b0;
            end
            step();
        end
        bus.cfg_we = 1'b0;
        bus.ks_ready = 1'b1;
        do_cfg(key_a, nonce_b, 32'd10);
        wait_valid(100, lat);
        check("rand_tail_latency", 512'(lat), 512'(22));
        check("rand_tail_ctr", 512'(bus.ks_ctr), 512'(10));

        // ChaCha8 with one quarter-round per cycle
        b8.key = RFC_KEY; b8.nonce = RFC_NONCE; b8.ctr_init = 32'd1; b8.ks_ready = 1'b1; b8.cfg_we = 1'b1;
        step();
        b8.cfg_we = 1'b0;
        lat = 0;
        while (!b8.ks_valid && lat < 100) begin step(); lat++; end
        check("c8_latency", 512'(lat), 512'(34));
        check("c8_ctr", 512'(b8.ks_ctr), 512'(1));
        check("c8_data", b8.ks_data, chacha_ref(RFC_KEY, RFC_NONCE, 32'd1, 8));
        step();
        lat = 0;
        while (!b8.ks_valid && lat < 100) begin step(); lat++; end
        check("c8_ctr2", 512'(b8.ks_ctr), 512'(2));
        check("c8_data2", b8.ks_data, chacha_ref(RFC_KEY, RFC_NONCE, 32'd2, 8));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
